rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Write-port arbiter and scoreboard for the general register file. It shares the register file's single write port between the in-order pipeline write-back stage and the long-latency unit (LDU: divider/multiplier). LDU results are buffered in a small FIFO until the port is free. A per-register busy scoreboard drives the decode-stage stall for registers whose LDU result is still outstanding. The block sits between the WB stage / LDU and the register file's `wb_ena`/`wb_reg`/write-data inputs.

## Interface
- `FIFO_DEPTH`, default 2: LDU result buffer entries; 1 to 4.
- `STARVE_MAX`, default 4: consecutive cycles in which the pipeline holds the port while the FIFO is non-empty before `arb_hold` asserts.
- `arb_clk`  in  1  clock; all state updates on the rising edge.
- `arb_rst_n`  in  1  reset; synchronous, active-low.
- `pipe_we`  in  1  pipeline WB write request.
- `pipe_reg`  in  5  pipeline WB destination.
- `pipe_wdata`  in  32  pipeline WB data.
- `ldu_req`  in  1  LDU result valid.
- `ldu_reg`  in  5  LDU result destination.
- `ldu_wdata`  in  32  LDU result data.
- `ldu_ack`  out  1  LDU result accepted this cycle.
- `iss_valid`  in  1  ID issues an LDU op this cycle.
- `iss_reg`  in  5  destination of the issued LDU op.
- `id_rj`, `id_rk`, `id_rd`  in  5 each  decode-stage source and destination registers.
- `id_rd_used`  in  1  `id_rd` is read or written by the decode instruction.
- `id_stall`  out  1  decode must hold this cycle.
- `arb_hold`  out  1  starvation hold; the front-end inserts a bubble.
- `rf_we`  out  1  register file write enable.
- `rf_waddr`  out  5  register file write address.
- `rf_wdata`  out  32  register file write data.

## Operation
- **Port mux (combinational).**
  - If `pipe_we` and `pipe_reg`≠0: drive the pipeline request.
  - Else if the FIFO is non-empty: drive the FIFO head and pop it on this edge.
  - Else: `rf_we`=0.
  - The pipeline always wins; it cannot be stalled at WB.
- **r0 handling.** A pipeline write to r0 is treated as no request, and the FIFO may use the port that cycle. An LDU result for r0 is acked but never pushed.
- **FIFO.**
  - `ldu_ack` = `ldu_req` && count<`FIFO_DEPTH`. A full FIFO gives no ack; the LDU holds its outputs.
  - Same-cycle push and pop are allowed; count is unchanged.
  - There is no pass-through: a pushed entry commits at the earliest on the next cycle.
- **Scoreboard.** 32 busy bits, bit 0 hard-wired 0.
  - `iss_valid` with `iss_reg`≠0 sets `busy[iss_reg]`.
  - A FIFO pop clears `busy[rf_waddr]`.
  - A set and a clear of the same register in the same cycle leave the bit set.
- **Stall.** `id_stall` = `busy[id_rj]` | `busy[id_rk]` | (`id_rd_used` & `busy[id_rd]`) | `arb_hold`.
  - Including `id_rd` covers RAW hazards through `id_rd` and WAW hazards on an outstanding destination, so a register is never issued twice while busy.
- **Starvation counter.**
  - Increments when the FIFO is non-empty and the pipeline holds the port.
  - Resets to 0 when the FIFO pops or becomes empty.
  - `arb_hold` = counter ≥ `STARVE_MAX`. It stays asserted until the FIFO pops.

## Timing
- Reset values: FIFO empty, all busy bits 0, counter 0, `ldu_ack`=0, `id_stall`=0, `arb_hold`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
- The reset takes priority over every same-edge event. FIFO contents and busy bits are discarded; the LDU must be flushed by the same reset.
- Pipeline write: zero latency, combinational to the RF, written at the same edge.
- LDU result: push at edge t; earliest `rf_we` in cycle t+1; the busy bit clears at the commit edge. A dependent instruction leaves ID no earlier than the cycle after the commit.
- `id_stall` and `ldu_ack` are combinational from registered state and the current inputs. `arb_hold` is registered-state only.
- FIFO full with a pop in the same cycle: `ldu_ack` stays 0 (the full check uses the current count).

## Configuration
- `RF_ARB_FWD_EN`: forwards results from the FIFO to ID.
- **Defined:**
  - Each FIFO entry is CAM-searched against `id_rj`/`id_rk`/`id_rd`.
  - Added outputs `id_fwd_hit1`, `id_fwd_hit2` (1 bit) and `id_fwd_data1`, `id_fwd_data2` (32 bits) serve the rj and rk/rd operands; on multiple hits the youngest matching entry wins.
  - The stall term for a busy register is suppressed when a FIFO entry matches it. A WAW hit still stalls.
- **Undefined:** these outputs are absent, and a busy register stalls until its commit.

## Test plan
- Reset with `arb_rst_n`=0 for 2 cycles while `ldu_req`=1 → all outputs 0 and nothing pushed; after release, FIFO empty and no busy bits set.
- Issue to r5; LDU returns r5=0x1234 while the pipeline is idle → ack at t, `rf_we`=1/r5/0x1234 at t+1, `busy[5]` clear after the t+1 edge; `id_rj`=5 stalls through t+1 and not at t+2.
- Pipeline writes every cycle while the LDU pushes r7 → no commit for 4 cycles, `arb_hold`=1 and `id_stall`=1. Once `pipe_we` drops, the r7 commit occurs and `arb_hold` deasserts the next cycle.
- Three LDU results back-to-back while the pipeline is busy (`FIFO_DEPTH`=2) → two acks, third `ldu_req` held unacked until the first pop. Commit order is preserved.
- Writes to r0: `pipe_we`/r0 in the same cycle as FIFO head r3 → r3 commits. LDU r0 result → acked, never written, never busy.
- With `RF_ARB_FWD_EN`: r9=0xCAFE queued behind pipeline writes, `id_rk`=9 → `id_fwd_hit2`=1, `id_fwd_data2`=0xCAFE, no stall.

Source files
------------

// File: rtl/rf_wport_arb_if.sv
// rf_wport_arb_if: write-path bundle between WB stage / LDU, the arbiter and the register file write port
interface rf_wport_arb_if;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_wdata;
    logic        ldu_req;
    logic [4:0]  ldu_reg;
    logic [31:0] ldu_wdata;
    logic        ldu_ack;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    modport master (
        output pipe_we, pipe_reg, pipe_wdata, ldu_req, ldu_reg, ldu_wdata,
        input  ldu_ack, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  pipe_we, pipe_reg, pipe_wdata, ldu_req, ldu_reg, ldu_wdata,
        output ldu_ack, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: RF write-port arbiter, LDU result FIFO and busy scoreboard; define RF_ARB_FWD_EN for FIFO-to-ID forwarding
module rf_wport_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        arb_clk,
    input  logic        arb_rst_n,
    rf_wport_arb_if.slave wp,
    input  logic        iss_valid,
    input  logic [4:0]  iss_reg,
    input  logic [4:0]  id_rj,
    input  logic [4:0]  id_rk,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_used,
    output logic        id_stall,
    output logic        arb_hold
`ifdef RF_ARB_FWD_EN
    ,
    output logic        id_fwd_hit1,
    output logic        id_fwd_hit2,
    output logic [31:0] id_fwd_data1,
    output logic [31:0] id_fwd_data2
`endif
);
    localparam logic [2:0] DEP = 3'(FIFO_DEPTH);
    localparam logic [7:0] ST_MAX = 8'(STARVE_MAX);
    logic [FIFO_DEPTH-1:0][4:0]  reg_q, reg_d;
    logic [FIFO_DEPTH-1:0][31:0] dat_q, dat_d;
    logic [2:0]  cnt_q, cnt_d, wi;
    logic [31:0] busy_q, busy_d;
    logic [7:0]  st_q, st_d;
    logic        pipe_v, pop, push, hit_j, hit_k;
    always_comb begin
        pipe_v = wp.pipe_we && wp.pipe_reg != 5'd0;
        pop = !pipe_v && cnt_q != 3'd0;
        wp.ldu_ack = arb_rst_n && wp.ldu_req && cnt_q < DEP;
        push = wp.ldu_ack && wp.ldu_reg != 5'd0;
        wp.rf_we = arb_rst_n && (pipe_v || pop);
        wp.rf_waddr = !arb_rst_n ? 5'd0 : pipe_v ? wp.pipe_reg : pop ? reg_q[0] : 5'd0;
        wp.rf_wdata = !arb_rst_n ? 32'd0 : pipe_v ? wp.pipe_wdata : pop ? dat_q[0] : 32'd0;
        // FIFO is a shift register: head always at slot 0, tail at slot cnt-1
        reg_d = pop ? reg_q >> 5 : reg_q;
        dat_d = pop ? dat_q >> 32 : dat_q;
        wi = cnt_q - {2'b0, pop};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && 3'(i) == wi) begin
                reg_d[i] = wp.ldu_reg;
                dat_d[i] = wp.ldu_wdata;
            end
        end
        cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
        busy_d = busy_q;
        if (pop) busy_d[reg_q[0]] = 1'b0;
        if (iss_valid) busy_d[iss_reg] = 1'b1;
        busy_d[0] = 1'b0;
        st_d = (!pipe_v || cnt_q == 3'd0) ? 8'd0 : st_q + {7'd0, st_q < ST_MAX};
        arb_hold = st_q >= ST_MAX;
        hit_j = 1'b0;
        hit_k = 1'b0;
`ifdef RF_ARB_FWD_EN
        id_fwd_data1 = 32'd0;
        id_fwd_data2 = 32'd0;
        // ascending scan so the youngest match overrides older ones
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (3'(i) < cnt_q && reg_q[i] == id_rj) begin
                hit_j = 1'b1;
                id_fwd_data1 = dat_q[i];
            end
            if (3'(i) < cnt_q && reg_q[i] == id_rk) begin
                hit_k = 1'b1;
                id_fwd_data2 = dat_q[i];
            end
        end
        id_fwd_hit1 = arb_rst_n && hit_j;
        id_fwd_hit2 = arb_rst_n && hit_k;
`endif
        id_stall = arb_rst_n && ((busy_q[id_rj] && !hit_j) || (busy_q[id_rk] && !hit_k)
                   || (id_rd_used && busy_q[id_rd]) || arb_hold);
    end
    always_ff @(posedge arb_clk) begin
        if (!arb_rst_n) begin
            reg_q <= '0;
            dat_q <= '0;
            cnt_q <= 3'd0;
            busy_q <= 32'd0;
            st_q <= 8'd0;
        end else begin
            reg_q <= reg_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            st_q <= st_d;
        end
    end
endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb: directed vectors for rf_wport_arb (forwarding checks only when RF_ARB_FWD_EN is defined)
module tb_rf_wport_arb;
    logic clk = 1'b0, rst_n = 1'b0;
    logic iss_valid = 1'b0, id_rd_used = 1'b0;
    logic [4:0] iss_reg = 5'd0, id_rj = 5'd0, id_rk = 5'd0, id_rd = 5'd0;
    logic id_stall, arb_hold;
    int n_chk = 0, n_bad = 0;
`ifdef RF_ARB_FWD_EN
    localparam bit FWD = 1'b1;
    logic hit1, hit2;
    logic [31:0] fd1, fd2;
`else
    localparam bit FWD = 1'b0;
`endif
    rf_wport_arb_if wp();
    rf_wport_arb dut (
        .arb_clk(clk), .arb_rst_n(rst_n), .wp(wp),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .id_rj(id_rj), .id_rk(id_rk), .id_rd(id_rd), .id_rd_used(id_rd_used),
        .id_stall(id_stall), .arb_hold(arb_hold)
`ifdef RF_ARB_FWD_EN
        , .id_fwd_hit1(hit1), .id_fwd_hit2(hit2), .id_fwd_data1(fd1), .id_fwd_data2(fd2)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pipe(input logic we, input logic [4:0] r, input logic [31:0] d);
        wp.pipe_we = we; wp.pipe_reg = r; wp.pipe_wdata = d;
    endtask
    task automatic ldu(input logic req, input logic [4:0] r, input logic [31:0] d);
        wp.ldu_req = req; wp.ldu_reg = r; wp.ldu_wdata = d;
    endtask
    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, {31'd0, wp.rf_we}, {31'd0, we});
        chk({tag, "_addr"}, {27'd0, wp.rf_waddr}, {27'd0, a});
        chk({tag, "_data"}, wp.rf_wdata, d);
    endtask
    initial begin
        pipe(1'b0, 5'd0, 32'd0);
        ldu(1'b1, 5'd3, 32'h33);
        iss_valid = 1'b1; iss_reg = 5'd4;
        tick();
        tick();
        #1;
        chk("rst_ack", {31'd0, wp.ldu_ack}, 32'd0);
        chk_rf("rst", 1'b0, 5'd0, 32'd0);
        chk("rst_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_hold", {31'd0, arb_hold}, 32'd0);
        rst_n = 1'b1; ldu(1'b0, 5'd0, 32'd0); iss_valid = 1'b0; id_rj = 5'd4; id_rk = 5'd3;
        #1;
        chk_rf("post_rst", 1'b0, 5'd0, 32'd0);
        chk("post_rst_stall", {31'd0, id_stall}, 32'd0);
        // scoreboard + LDU commit latency
        iss_valid = 1'b1; iss_reg = 5'd5; id_rj = 5'd0; id_rk = 5'd0;
        tick();
        iss_valid = 1'b0; id_rj = 5'd5; ldu(1'b1, 5'd5, 32'h1234);
        #1;
        chk("r5_ack", {31'd0, wp.ldu_ack}, 32'd1);
        chk("r5_t_rfwe", {31'd0, wp.rf_we}, 32'd0);
        chk("r5_t_stall", {31'd0, id_stall}, 32'd1);
        tick();
        ldu(1'b0, 5'd0, 32'd0);
        #1;
        chk_rf("r5_t1", 1'b1, 5'd5, 32'h1234);
        chk("r5_t1_stall", {31'd0, id_stall}, FWD ? 32'd0 : 32'd1);
        tick();
        #1;
        chk("r5_t2_stall", {31'd0, id_stall}, 32'd0);
        chk("r5_t2_rfwe", {31'd0, wp.rf_we}, 32'd0);
        // starvation
        id_rj = 5'd0; iss_valid = 1'b1; iss_reg = 5'd7; pipe(1'b1, 5'd2, 32'h100);
        tick();
        iss_valid = 1'b0; ldu(1'b1, 5'd7, 32'h77); pipe(1'b1, 5'd2, 32'h101);
        #1;
        chk("r7_ack", {31'd0, wp.ldu_ack}, 32'd1);
        chk("r7_pipe_addr", {27'd0, wp.rf_waddr}, 32'd2);
        tick();
        ldu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pipe(1'b1, 5'd2, 32'h200 + 32'(i));
            #1;
            chk_rf("starve_pipe", 1'b1, 5'd2, 32'h200 + 32'(i));
            chk("starve_nohold", {31'd0, arb_hold}, 32'd0);
            tick();
        end
        #1;
        chk("starve_hold", {31'd0, arb_hold}, 32'd1);
        chk("starve_stall", {31'd0, id_stall}, 32'd1);
        tick();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        chk_rf("r7_commit", 1'b1, 5'd7, 32'h77);
        chk("r7_commit_hold", {31'd0, arb_hold}, 32'd1);
        tick();
        id_rj = 5'd7;
        #1;
        chk("r7_hold_off", {31'd0, arb_hold}, 32'd0);
        chk("r7_stall_off", {31'd0, id_stall}, 32'd0);
        // FIFO full: three back-to-back results
        id_rj = 5'd0; pipe(1'b1, 5'd2, 32'h300); ldu(1'b1, 5'd10, 32'hA0);
        #1;
        chk("q_ack0", {31'd0, wp.ldu_ack}, 32'd1);
        tick();
        ldu(1'b1, 5'd11, 32'hB0);
        #1;
        chk("q_ack1", {31'd0, wp.ldu_ack}, 32'd1);
        tick();
        ldu(1'b1, 5'd12, 32'hC0);
        #1;
        chk("q_full_noack", {31'd0, wp.ldu_ack}, 32'd0);
        tick();
        pipe(1'b0, 5'd0, 32'd0);
        #1;
        chk("q_full_pop_noack", {31'd0, wp.ldu_ack}, 32'd0);
        chk_rf("q_c0", 1'b1, 5'd10, 32'hA0);
        tick();
        #1;
        chk("q_ack2", {31'd0, wp.ldu_ack}, 32'd1);
        chk_rf("q_c1", 1'b1, 5'd11, 32'hB0);
        tick();
        ldu(1'b0, 5'd0, 32'd0);
        #1;
        chk_rf("q_c2", 1'b1, 5'd12, 32'hC0);
        tick();
        #1;
        chk("q_empty", {31'd0, wp.rf_we}, 32'd0);
        // r0 handling
        pipe(1'b1, 5'd2, 32'h400); ldu(1'b1, 5'd3, 32'h33);
        tick();
        pipe(1'b1, 5'd0, 32'h999); ldu(1'b0, 5'd0, 32'd0);
        #1;
        chk_rf("r0_pipe", 1'b1, 5'd3, 32'h33);
        tick();
        pipe(1'b0, 5'd0, 32'd0); ldu(1'b1, 5'd0, 32'h99); iss_valid = 1'b1; iss_reg = 5'd0;
        #1;
        chk("r0_ldu_ack", {31'd0, wp.ldu_ack}, 32'd1);
        tick();
        ldu(1'b0, 5'd0, 32'd0); iss_valid = 1'b0;
        #1;
        chk("r0_no_commit", {31'd0, wp.rf_we}, 32'd0);
        chk("r0_no_busy", {31'd0, id_stall}, 32'd0);
`ifdef RF_ARB_FWD_EN
        pipe(1'b1, 5'd2, 32'h500); iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0; ldu(1'b1, 5'd9, 32'hCAFE);
        tick();
        ldu(1'b0, 5'd0, 32'd0); id_rk = 5'd9;
        #1;
        chk("fwd_hit2", {31'd0, hit2}, 32'd1);
        chk("fwd_data2", fd2, 32'hCAFE);
        chk("fwd_hit1", {31'd0, hit1}, 32'd0);
        chk("fwd_nostall", {31'd0, id_stall}, 32'd0);
        pipe(1'b0, 5'd0, 32'd0);
        tick();
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
